// File: rtl/div32_seq_pkg.sv
// Shared types and constants for the sequential unsigned divider.
package div32_seq_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] quotient;
        logic [WIDTH-1:0] remainder;
        logic             div_zero;
    } div_result_t;

endpackage

// File: rtl/div32_seq_if.sv
// Start/done request and result bus between the control FSM and the divider.
interface div32_seq_if;
    import div32_seq_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/div32_seq_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carry.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
    end

    assign s  = p ^ c[31:0];
    assign co = c[32];

endmodule

// File: rtl/div32_seq.sv
// Unsigned 32-bit restoring divider, one quotient bit per clock, start/done handshake.
module div32_seq
    import div32_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    div32_seq_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [WIDTH-1:0]  d_q, d_d;
    div_result_t       res_q, res_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  t_c;
    logic [WIDTH-1:0]  diff_c;
    logic              no_borrow_c;
    logic [WIDTH-1:0]  r_nxt_c;
    logic [WIDTH-1:0]  q_nxt_c;

    // R never reaches 2^31 before the final shift, so dropping R[31] loses nothing.
    assign t_c = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    cla32 u_sub (
        .a  (t_c),
        .b  (~d_q),
        .ci (1'b1),
        .s  (diff_c),
        .co (no_borrow_c)
    );

    assign r_nxt_c = no_borrow_c ? diff_c : t_c;
    assign q_nxt_c = {q_q[WIDTH-2:0], no_borrow_c};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        res_d   = res_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        res_d.quotient  = DIV0_QUOT;
                        res_d.remainder = bus.dividend;
                        res_d.div_zero  = 1'b1;
                        state_d         = DONE;
                        done_d          = 1'b1;
                    end else begin
                        q_d            = bus.dividend;
                        r_d            = '0;
                        d_d            = bus.divisor;
                        cnt_d          = '0;
                        res_d.div_zero = 1'b0;
                        state_d        = CALC;
                        busy_d         = 1'b1;
                    end
                end
            end
            CALC: begin
                q_d   = q_nxt_c;
                r_d   = r_nxt_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_d.quotient  = q_nxt_c;
                    res_d.remainder = r_nxt_c;
                    state_d         = DONE;
                    busy_d          = 1'b0;
                    done_d          = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = res_q.quotient;
    assign bus.remainder = res_q.remainder;
    assign bus.div_zero  = res_q.div_zero;

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: vector table, handshake corner sequences and random operands via a scoreboard.
module tb_div32_seq;
    import div32_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    div32_seq_if dif ();

    div32_seq u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        bit          glitch;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_q   = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset_n && dif.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", 64'(dif.quotient), 64'(mon_e.q));
                chk("remainder", 64'(dif.remainder), 64'(mon_e.r));
                chk("div_zero", 64'(dif.div_zero), 64'(mon_e.dz));
                if (!mon_e.dz) begin
                    chk("identity", 64'(dif.quotient) * 64'(mon_e.b) + 64'(dif.remainder), 64'(mon_e.a));
                    chk("rem_lt_div", 64'(dif.remainder < mon_e.b), 64'd1);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, b, q, r, input logic dz);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [31:0] a, b, q, r, input logic dz, input int lat, input bit glitch);
        int n;
        push_exp(a, b, q, r, dz);
        dif.dividend = a;
        dif.divisor  = b;
        dif.start    = 1'b1;
        @(negedge clk);
        n = 1;
        dif.start = 1'b0;
        chk("busy_after_start", 64'(dif.busy), 64'(lat == 33));
        while (dif.done !== 1'b1 && n < 40) begin
            if (glitch && n == 10) begin
                dif.start    = 1'b1;
                dif.dividend = 32'd50;
                dif.divisor  = 32'd5;
            end else begin
                dif.start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (n == 16) chk("result_stable_in_calc", 64'(dif.quotient), 64'(last_q));
        end
        dif.start = 1'b0;
        if (dif.done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles expected %0d", n, lat);
        end else begin
            chk("latency", 64'(n), 64'(lat));
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(dif.done), 64'd0);
        chk("busy_after_done", 64'(dif.busy), 64'd0);
        chk("quotient_held", 64'(dif.quotient), 64'(q));
        chk("div_zero_held", 64'(dif.div_zero), 64'(dz));
        last_q = q;
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rdz;
        int          m;
        int          seen;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33, 1'b0};
        vecs[3] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 33, 1'b0};
        vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33, 1'b0};
        vecs[5] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1,  1'b0};
        vecs[6] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0, 33, 1'b0};
        vecs[8] = '{32'h8000_0000,  32'h8000_0001,  32'd0,          32'h8000_0000,  1'b0, 33, 1'b0};
        vecs[9] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0, 33, 1'b1};

        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(dif.busy), 64'd0);
        chk("reset_done", 64'(dif.done), 64'd0);
        chk("reset_quotient", 64'(dif.quotient), 64'd0);
        chk("reset_remainder", 64'(dif.remainder), 64'd0);
        chk("reset_div_zero", 64'(dif.div_zero), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, vecs[i].glitch);

        // start held high: second request is accepted two cycles after the first done.
        push_exp(32'd20, 32'd3, 32'd6, 32'd2, 1'b0);
        dif.dividend = 32'd20;
        dif.divisor  = 32'd3;
        dif.start    = 1'b1;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (dif.done !== 1'b1 && m < 40);
        chk("b2b_first_latency", 64'(m), 64'd33);
        push_exp(32'd21, 32'd4, 32'd5, 32'd1, 1'b0);
        dif.dividend = 32'd21;
        dif.divisor  = 32'd4;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (dif.done !== 1'b1 && m < 50);
        chk("b2b_period", 64'(m), 64'd34);
        dif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        last_q = 32'd5;

        // Abort mid-division with reset after leaving nonzero results behind.
        run_op(32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1, 1, 1'b0);
        dif.dividend = 32'd1000;
        dif.divisor  = 32'd7;
        dif.start    = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(dif.busy), 64'd0);
        chk("abort_done", 64'(dif.done), 64'd0);
        chk("abort_quotient", 64'(dif.quotient), 64'd0);
        chk("abort_remainder", 64'(dif.remainder), 64'd0);
        chk("abort_div_zero", 64'(dif.div_zero), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.done === 1'b1) seen++;
        end
        chk("no_done_after_abort", 64'(seen), 64'd0);
        last_q = '0;

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 49) == 0) rb = '0;
            if (rb == '0) begin
                rq = 32'hFFFF_FFFF; rr = ra; rdz = 1'b1;
            end else begin
                rq = ra / rb; rr = ra % rb; rdz = 1'b0;
            end
            run_op(ra, rb, rq, rr, rdz, (rb == '0) ? 1 : 33, 1'b0);
        end

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
